// File: rtl/dma_channel_reg_file.sv
// rtl/dma_channel_reg_file.sv - per-channel DMA address/count/mode registers
// Processor access by {channel, field}; sequencer advances ch_select one word per xfer_step.
module dma_channel_reg_file #(
  parameter int NCH = 4,
  parameter int AW  = 16,
  parameter int CW  = 16,
  parameter int DW  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cs,
  input  logic                     IOR,
  input  logic                     IOW,
  input  logic [$clog2(NCH)+1:0]   reg_addr,
  input  logic [DW-1:0]            data_in,
  output logic [DW-1:0]            data_out,
  input  logic [$clog2(NCH)-1:0]   ch_select,
  input  logic                     xfer_step,
  output logic [AW-1:0]            cur_address_out,
  output logic [CW-1:0]            cur_word_out,
  output logic [NCH-1:0]           ch_active,
  output logic                     tc_pulse,
  output logic [NCH-1:0]           tc_flag,
  output logic                     processor_write_done
);

  localparam int CHW = $clog2(NCH);

  logic [AW-1:0] base_addr [NCH];
  logic [AW-1:0] cur_addr  [NCH];
  logic [CW-1:0] base_cnt  [NCH];
  logic [CW-1:0] cur_cnt   [NCH];
  logic [2:0]    mode      [NCH];

  logic [CHW-1:0] acc_ch;
  logic [1:0]     field;
  logic           acc_ok, sel_ok;
  logic [CHW-1:0] sel_idx;
  logic           wr_en, rd_en;
  logic [NCH-1:0] wr_hit;
  logic           step_ok, step_last;
  logic [NCH-1:0] tc_next;
  logic           unused_data;

  assign acc_ch  = reg_addr[CHW+1:2];
  assign field   = reg_addr[1:0];
  assign acc_ok  = {1'b0, acc_ch} < (CHW+1)'(NCH);
  assign sel_ok  = {1'b0, ch_select} < (CHW+1)'(NCH);
  assign sel_idx = sel_ok ? ch_select : '0;
  assign wr_en   = cs && IOW && !IOR;
  assign rd_en   = cs && IOR && !IOW;
  assign unused_data = ^data_in;

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_hit[i] = wr_en && acc_ok && (acc_ch == CHW'(i));
    end
  end

  // A processor write to the stepping channel wins; the step is dropped.
  assign step_ok   = sel_ok && xfer_step && !mode[sel_idx][2] &&
                     (cur_cnt[sel_idx] != '0) && !wr_hit[sel_idx];
  assign step_last = step_ok && (cur_cnt[sel_idx] == CW'(1));

  always_comb begin
    tc_next = tc_flag;
    if (rd_en && field == 2'd3) tc_next = '0;
    for (int i = 0; i < NCH; i++) begin
      if (wr_hit[i] && !field[1]) tc_next[i] = 1'b0;
    end
    if (step_last) tc_next[sel_idx] = 1'b1;
  end

  always_comb begin
    data_out = '0;
    if (!reset && rd_en && acc_ok) begin
      case (field)
        2'd0:    data_out = DW'(cur_addr[acc_ch]);
        2'd1:    data_out = DW'(cur_cnt[acc_ch]);
        2'd2:    data_out = DW'(mode[acc_ch]);
        default: data_out = DW'(tc_flag);
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ch_active[i] = !mode[i][2] && (cur_cnt[i] != '0);
    end
  end

  assign cur_address_out = sel_ok ? cur_addr[sel_idx] : '0;
  assign cur_word_out    = sel_ok ? cur_cnt[sel_idx] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        base_addr[i] <= '0;
        cur_addr[i]  <= '0;
        base_cnt[i]  <= '0;
        cur_cnt[i]   <= '0;
        mode[i]      <= 3'b100;
      end
      tc_flag              <= '0;
      tc_pulse             <= 1'b0;
      processor_write_done <= 1'b0;
    end else begin
      processor_write_done <= wr_en;
      tc_pulse             <= step_last;
      tc_flag              <= tc_next;
      for (int i = 0; i < NCH; i++) begin
        if (wr_hit[i]) begin
          case (field)
            2'd0: begin
              base_addr[i] <= data_in[AW-1:0];
              cur_addr[i]  <= data_in[AW-1:0];
            end
            2'd1: begin
              base_cnt[i] <= data_in[CW-1:0];
              cur_cnt[i]  <= data_in[CW-1:0];
            end
            2'd2:    mode[i] <= data_in[2:0];
            default: ;
          endcase
        end else if (step_ok && sel_idx == CHW'(i)) begin
          // Autoinit reloads from base instead of leaving the channel at zero.
          if (step_last && mode[i][0]) begin
            cur_addr[i] <= base_addr[i];
            cur_cnt[i]  <= base_cnt[i];
          end else begin
            cur_addr[i] <= mode[i][1] ? cur_addr[i] - AW'(1) : cur_addr[i] + AW'(1);
            cur_cnt[i]  <= cur_cnt[i] - CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_channel_reg_file.sv
// tb/tb_dma_channel_reg_file.sv - bench for dma_channel_reg_file
module tb_dma_channel_reg_file;
  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0, IOR = 1'b0, IOW = 1'b0;
  logic [3:0]  reg_addr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic [1:0]  ch_select = '0;
  logic        xfer_step = 1'b0;
  logic [15:0] cur_address_out, cur_word_out;
  logic [NCH-1:0] ch_active, tc_flag;
  logic        tc_pulse, processor_write_done;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_ba [NCH];
  logic [15:0] m_ca [NCH];
  logic [15:0] m_bc [NCH];
  logic [15:0] m_cc [NCH];
  logic [2:0]  m_mode [NCH];
  logic [NCH-1:0] m_tc;
  logic        e_tcp, e_wd;

  dma_channel_reg_file #(.NCH(NCH), .AW(16), .CW(16), .DW(16)) dut (
    .clk(clk), .reset(reset), .cs(cs), .IOR(IOR), .IOW(IOW),
    .reg_addr(reg_addr), .data_in(data_in), .data_out(data_out),
    .ch_select(ch_select), .xfer_step(xfer_step),
    .cur_address_out(cur_address_out), .cur_word_out(cur_word_out),
    .ch_active(ch_active), .tc_pulse(tc_pulse), .tc_flag(tc_flag),
    .processor_write_done(processor_write_done));

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_ba[i] = 0; m_ca[i] = 0; m_bc[i] = 0; m_cc[i] = 0; m_mode[i] = 3'b100;
    end
    m_tc = '0; e_tcp = 0; e_wd = 0;
  endtask

  function automatic logic [15:0] model_read(input int ch, input int f);
    case (f)
      0: return m_ca[ch];
      1: return m_cc[ch];
      2: return {13'b0, m_mode[ch]};
      default: return {12'b0, m_tc};
    endcase
  endfunction

  function automatic logic [NCH-1:0] model_active();
    logic [NCH-1:0] a;
    for (int i = 0; i < NCH; i++) a[i] = !m_mode[i][2] && m_cc[i] != 0;
    return a;
  endfunction

  task automatic drive(input bit w, input bit r, input int ch, input int f,
                       input logic [15:0] d, input bit st, input int sc);
    cs = w | r; IOW = w; IOR = r;
    reg_addr = 4'(ch * 4 + f); data_in = d;
    xfer_step = st; ch_select = 2'(sc);
  endtask

  // Applies the behavioural rules of one clock edge to the model, using the driven inputs.
  task automatic edge_step();
    bit wr, rd, st;
    int wch, wf, c;
    logic [15:0] d;
    logic [NCH-1:0] ntc;
    wr = cs && IOW && !IOR; rd = cs && IOR && !IOW;
    wch = int'(reg_addr[3:2]); wf = int'(reg_addr[1:0]); d = data_in;
    st = xfer_step; c = int'(ch_select);
    @(posedge clk);
    ntc = m_tc; e_wd = wr; e_tcp = 0;
    if (rd && wf == 3) ntc = '0;
    if (st && !m_mode[c][2] && m_cc[c] != 0 && !(wr && wch == c)) begin
      if (m_cc[c] == 1) begin ntc[c] = 1; e_tcp = 1; end
      if (m_cc[c] == 1 && m_mode[c][0]) begin
        m_ca[c] = m_ba[c]; m_cc[c] = m_bc[c];
      end else begin
        m_ca[c] = m_mode[c][1] ? m_ca[c] - 16'd1 : m_ca[c] + 16'd1;
        m_cc[c] = m_cc[c] - 16'd1;
      end
    end
    if (wr) begin
      case (wf)
        0: begin m_ba[wch] = d; m_ca[wch] = d; ntc[wch] = 0; end
        1: begin m_bc[wch] = d; m_cc[wch] = d; ntc[wch] = 0; end
        2: m_mode[wch] = d[2:0];
        default: ;
      endcase
    end
    m_tc = ntc;
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    drive(0, 1, 0, 2, 16'h0, 0, 0);
    #1;
    checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL reset_data_out got=%h exp=0000", data_out); end
    checks++; if ({tc_flag, ch_active, tc_pulse, processor_write_done} !== '0) begin errors++; $display("FAIL reset_flags got=%b exp=0", {tc_flag, ch_active, tc_pulse, processor_write_done}); end
    checks++; if ({cur_address_out, cur_word_out} !== 32'h0) begin errors++; $display("FAIL reset_cur got=%h exp=0", {cur_address_out, cur_word_out}); end
    @(negedge clk); reset = 0; #1;
    checks++; if (data_out !== 16'h0004) begin errors++; $display("FAIL reset_mode got=%h exp=0004", data_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_program_readback();
    logic [15:0] vals [3];
    vals[0] = 16'h012C; vals[1] = 16'd10; vals[2] = 16'd0;
    for (int f = 0; f < 3; f++) begin
      drive(1, 0, 1, f, vals[f], 0, 1); edge_step();
      checks++; if (processor_write_done !== 1'b1) begin errors++; $display("FAIL prog_wd f=%0d got=%b exp=1", f, processor_write_done); end
    end
    drive(0, 1, 1, 0, 16'h0, 0, 1); #1;
    checks++; if (data_out !== 16'h012C) begin errors++; $display("FAIL prog_rd_addr got=%h exp=012c", data_out); end
    edge_step();
    checks++; if (processor_write_done !== 1'b0) begin errors++; $display("FAIL prog_wd_idle got=%b exp=0", processor_write_done); end
    drive(0, 1, 1, 1, 16'h0, 0, 1); #1;
    checks++; if (data_out !== 16'd10) begin errors++; $display("FAIL prog_rd_cnt got=%h exp=000a", data_out); end
    checks++; if (ch_active !== 4'b0010) begin errors++; $display("FAIL prog_active got=%b exp=0010", ch_active); end
    edge_step();
  endtask

  task automatic test_tc_increment();
    drive(1, 0, 2, 0, 16'h0190, 0, 2); edge_step();
    drive(1, 0, 2, 1, 16'd2, 0, 2); edge_step();
    drive(1, 0, 2, 2, 16'd0, 0, 2); edge_step();
    drive(0, 0, 0, 0, 16'h0, 1, 2); edge_step();
    checks++; if (cur_address_out !== 16'h0191 || tc_pulse !== 1'b0) begin errors++; $display("FAIL tc_step1 addr=%h pulse=%b exp=0191/0", cur_address_out, tc_pulse); end
    edge_step();
    checks++; if (cur_address_out !== 16'h0192 || cur_word_out !== 16'd0) begin errors++; $display("FAIL tc_step2 addr=%h cnt=%h exp=0192/0000", cur_address_out, cur_word_out); end
    checks++; if (tc_pulse !== 1'b1 || tc_flag[2] !== 1'b1) begin errors++; $display("FAIL tc_pulse pulse=%b flag=%b exp=1/1", tc_pulse, tc_flag[2]); end
    edge_step();
    checks++; if (cur_address_out !== 16'h0192 || tc_pulse !== 1'b0 || ch_active[2] !== 1'b0) begin errors++; $display("FAIL tc_step3 addr=%h pulse=%b act=%b exp=0192/0/0", cur_address_out, tc_pulse, ch_active[2]); end
  endtask

  task automatic test_autoinit();
    drive(1, 0, 0, 0, 16'h0064, 0, 0); edge_step();
    drive(1, 0, 0, 1, 16'd3, 0, 0); edge_step();
    drive(1, 0, 0, 2, 16'd3, 0, 0); edge_step();
    drive(0, 0, 0, 0, 16'h0, 1, 0);
    edge_step();
    checks++; if (cur_address_out !== 16'h0063) begin errors++; $display("FAIL auto_dec got=%h exp=0063", cur_address_out); end
    edge_step(); edge_step();
    checks++; if (cur_address_out !== 16'h0064 || cur_word_out !== 16'd3 || tc_flag[0] !== 1'b1) begin errors++; $display("FAIL auto_reload addr=%h cnt=%h flag=%b exp=0064/0003/1", cur_address_out, cur_word_out, tc_flag[0]); end
    drive(0, 1, 0, 3, 16'h0, 0, 0); #1;
    checks++; if (data_out[0] !== 1'b1 || data_out !== model_read(0, 3)) begin errors++; $display("FAIL auto_status got=%h exp=%h", data_out, model_read(0, 3)); end
    edge_step();
    checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL auto_status_clr got=%h exp=0000", data_out); end
    drive(0, 0, 0, 0, 16'h0, 0, 0); edge_step();
  endtask

  task automatic test_wrap();
    drive(1, 0, 1, 0, 16'hFFFF, 0, 1); edge_step();
    drive(1, 0, 1, 1, 16'd2, 0, 1); edge_step();
    drive(1, 0, 1, 2, 16'd0, 0, 1); edge_step();
    drive(0, 0, 0, 0, 16'h0, 1, 1); edge_step();
    checks++; if (cur_address_out !== 16'h0000) begin errors++; $display("FAIL wrap_inc got=%h exp=0000", cur_address_out); end
    drive(1, 0, 1, 2, 16'd2, 0, 1); edge_step();
    drive(0, 0, 0, 0, 16'h0, 1, 1); edge_step();
    checks++; if (cur_address_out !== 16'hFFFF || tc_pulse !== 1'b1) begin errors++; $display("FAIL wrap_dec addr=%h pulse=%b exp=ffff/1", cur_address_out, tc_pulse); end
  endtask

  task automatic test_collision();
    drive(1, 0, 3, 0, 16'h0AAA, 0, 3); edge_step();
    drive(1, 0, 3, 1, 16'd9, 0, 3); edge_step();
    drive(1, 0, 3, 2, 16'd0, 0, 3); edge_step();
    drive(1, 0, 3, 1, 16'd5, 1, 3); edge_step();
    checks++; if (cur_word_out !== 16'd5 || cur_address_out !== 16'h0AAA) begin errors++; $display("FAIL coll_same cnt=%h addr=%h exp=0005/0aaa", cur_word_out, cur_address_out); end
    drive(1, 0, 0, 2, 16'd4, 1, 3); edge_step();
    checks++; if (cur_word_out !== 16'd4 || cur_address_out !== 16'h0AAB || ch_active[0] !== 1'b0) begin errors++; $display("FAIL coll_other cnt=%h addr=%h act0=%b exp=0004/0aab/0", cur_word_out, cur_address_out, ch_active[0]); end
    drive(1, 0, 3, 2, 16'd4, 0, 3); edge_step();
    drive(0, 0, 0, 0, 16'h0, 1, 3); edge_step();
    checks++; if (cur_word_out !== 16'd4 || ch_active[3] !== 1'b0) begin errors++; $display("FAIL masked cnt=%h act=%b exp=0004/0", cur_word_out, ch_active[3]); end
    cs = 1; IOW = 1; IOR = 1; reg_addr = 4'(3 * 4 + 1); data_in = 16'h0077; xfer_step = 0; #1;
    checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL illegal_rd got=%h exp=0000", data_out); end
    edge_step();
    checks++; if (processor_write_done !== 1'b0 || cur_word_out !== 16'd4) begin errors++; $display("FAIL illegal_wr wd=%b cnt=%h exp=0/0004", processor_write_done, cur_word_out); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seen;
    for (int k = 0; k < 4; k++) begin
      drive(k < 3, 0, k, 3, 16'hBEEF, 0, 0); edge_step();
      seen[k] = processor_write_done;
    end
    checks++; if (seen !== 4'b0111) begin errors++; $display("FAIL b2b_wd got=%b exp=0111", seen); end
  endtask

  task automatic test_random();
    bit w, r, st;
    int ch, f, sc;
    logic [15:0] d;
    for (int n = 0; n < 400; n++) begin
      w = ($urandom % 3) == 0;
      r = !w && ($urandom % 3) == 0;
      ch = $urandom % NCH; f = $urandom % 4; sc = $urandom % NCH;
      st = ($urandom % 4) != 0;
      case (f)
        1: d = 16'($urandom % 5);
        2: d = 16'($urandom % 8);
        default: d = ($urandom % 3 == 0) ? 16'hFFFF : 16'($urandom);
      endcase
      drive(w, r, ch, f, d, st, sc);
      if (($urandom % 25) == 0) begin cs = 1; IOW = 1; IOR = 1; end
      #1;
      checks++; if (data_out !== ((cs && IOR && !IOW) ? model_read(ch, f) : 16'h0)) begin errors++; $display("FAIL rnd_rd n=%0d got=%h exp=%h", n, data_out, (cs && IOR && !IOW) ? model_read(ch, f) : 16'h0); end
      edge_step();
      checks++; if (cur_address_out !== m_ca[sc] || cur_word_out !== m_cc[sc]) begin errors++; $display("FAIL rnd_cur n=%0d got=%h/%h exp=%h/%h", n, cur_address_out, cur_word_out, m_ca[sc], m_cc[sc]); end
      checks++; if (tc_flag !== m_tc || ch_active !== model_active()) begin errors++; $display("FAIL rnd_flags n=%0d got=%b/%b exp=%b/%b", n, tc_flag, ch_active, m_tc, model_active()); end
      checks++; if (tc_pulse !== e_tcp || processor_write_done !== e_wd) begin errors++; $display("FAIL rnd_pulses n=%0d got=%b/%b exp=%b/%b", n, tc_pulse, processor_write_done, e_tcp, e_wd); end
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 2, 1, 16'd1, 0, 2); edge_step();
    drive(1, 0, 2, 2, 16'd0, 0, 2); edge_step();
    drive(1, 0, 1, 0, 16'h1234, 1, 2); edge_step();
    checks++; if (tc_pulse !== 1'b1 || processor_write_done !== 1'b1) begin errors++; $display("FAIL rmid_pre pulse=%b wd=%b exp=1/1", tc_pulse, processor_write_done); end
    #1; reset = 1; #1;
    checks++; if (tc_pulse !== 1'b0 || processor_write_done !== 1'b0 || tc_flag !== '0 || ch_active !== '0) begin errors++; $display("FAIL rmid_async pulse=%b wd=%b flag=%b act=%b exp=0", tc_pulse, processor_write_done, tc_flag, ch_active); end
    checks++; if (cur_address_out !== 16'h0 || cur_word_out !== 16'h0) begin errors++; $display("FAIL rmid_cur got=%h/%h exp=0", cur_address_out, cur_word_out); end
    drive(0, 0, 0, 0, 16'h0, 0, 0);
    @(negedge clk); reset = 0; model_reset();
    for (int c = 0; c < NCH; c++) begin
      drive(0, 1, c, 2, 16'h0, 0, 0); #1;
      checks++; if (data_out !== 16'h0004) begin errors++; $display("FAIL rmid_mode ch=%0d got=%h exp=0004", c, data_out); end
    end
    drive(0, 0, 0, 0, 16'h0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_program_readback();
    test_tc_increment();
    test_autoinit();
    test_wrap();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
